// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: sweeps every register to zero after reset,
// then merges two writeback requesters onto one registered write port using round-robin.
module rf_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              WE3,
    output logic [ADDR_W-1:0] A3,
    output logic [DATA_W-1:0] WD3,
    output logic              busy
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_REG = '1;

    state_t            r_state;
    logic [ADDR_W-1:0] r_count;
    logic              r_last_b;
    logic              r_we3;
    logic [ADDR_W-1:0] r_a3;
    logic [DATA_W-1:0] r_wd3;

    logic              w_run;
    logic              w_a_win;
    logic              w_b_win;
    logic              w_grant;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    assign w_run = (r_state == ST_RUN);

    // Each grant depends only on the valids and the pointer, never on the other ready.
    assign w_a_win = a_valid & (~b_valid | r_last_b);
    assign w_b_win = b_valid & (~a_valid | ~r_last_b);

    assign a_ready = w_run & w_a_win;
    assign b_ready = w_run & w_b_win;
    assign busy    = ~w_run;

    assign w_grant = a_ready | b_ready;
    assign w_addr  = a_ready ? a_addr : b_addr;
    assign w_data  = a_ready ? a_data : b_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_CLEAR;
            r_count  <= '0;
            r_last_b <= 1'b1;
            r_we3    <= 1'b0;
            r_a3     <= '0;
            r_wd3    <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_we3 <= 1'b1;
                    r_a3  <= r_count;
                    r_wd3 <= '0;
                    // The counter parks on the last register so the sweep never repeats.
                    if (r_count == LAST_REG) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_grant) begin
                        r_we3    <= (w_addr != '0);
                        r_a3     <= w_addr;
                        r_wd3    <= w_data;
                        r_last_b <= b_ready;
                    end else begin
                        r_we3 <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_we3   <= 1'b0;
                end
            endcase
        end
    end

    assign WE3 = r_we3;
    assign A3  = r_a3;
    assign WD3 = r_wd3;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: clear-sweep timing, round-robin table vectors through
// an expected-write queue, and reset in the middle of RUN and of the sweep.
module tb_rf_write_arbiter;

    logic        clk;
    logic        reset;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        b_ready;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic        er_a;
        logic        er_b;
        logic        e_we;
        logic [4:0]  e_a3;
        logic [31:0] e_wd;
    } vec_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
    } exp_t;

    exp_t q[$];
    vec_t tbl[13];

    rf_write_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk     (clk),
        .reset   (reset),
        .a_valid (a_valid),
        .a_addr  (a_addr),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_addr  (b_addr),
        .b_data  (b_data),
        .b_ready (b_ready),
        .WE3     (WE3),
        .A3      (A3),
        .WD3     (WD3),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                                input logic er_a, input logic er_b, input logic e_we,
                                input logic [4:0] e_a3, input logic [31:0] e_wd);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad;
        v.bv = bv; v.ba = ba; v.bd = bd;
        v.er_a = er_a; v.er_b = er_b;
        v.e_we = e_we; v.e_a3 = e_a3; v.e_wd = e_wd;
        return v;
    endfunction

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [31:0] bd);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
    endtask

    // Entered 1 time unit after a posedge; one clock per vector.
    task automatic apply(input vec_t v);
        exp_t e;
        drive(v.av, v.aa, v.ad, v.bv, v.ba, v.bd);
        #3;
        chk("a_ready", 32'(a_ready), 32'(v.er_a));
        chk("b_ready", 32'(b_ready), 32'(v.er_b));
        chk("busy_run", 32'(busy), 32'd0);
        e.we = v.e_we; e.a3 = v.e_a3; e.wd = v.e_wd;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard: actual=empty required=entry");
        end else begin
            e = q.pop_front();
            chk("WE3", 32'(WE3), 32'(e.we));
            chk("A3", 32'(A3), 32'(e.a3));
            chk("WD3", WD3, e.wd);
        end
    endtask

    task automatic sweep(input int n, input bit full);
        for (int i = 0; i < n; i++) begin
            #3;
            chk("sweep_a_ready", 32'(a_ready), 32'd0);
            chk("sweep_b_ready", 32'(b_ready), 32'd0);
            chk("sweep_busy", 32'(busy), 32'd1);
            @(posedge clk);
            #1;
            chk("sweep_WE3", 32'(WE3), 32'd1);
            chk("sweep_A3", 32'(A3), 32'(i));
            chk("sweep_WD3", WD3, 32'd0);
        end
        if (full) chk("busy_after_sweep", 32'(busy), 32'd0);
    endtask

    initial begin
        vec_t prev;
        vec_t cur;
        //             av aa  ad           bv ba  bd           ra rb we a3  wd
        tbl[0]  = mk(0, 0,  0,            0, 0,  0,            0, 0, 0, 31, 32'h0);
        tbl[1]  = mk(1, 5,  32'h3,        0, 0,  0,            1, 0, 1, 5,  32'h3);
        tbl[2]  = mk(0, 0,  0,            1, 9,  32'h99,       0, 1, 1, 9,  32'h99);
        tbl[3]  = mk(1, 1,  32'hA,        1, 2,  32'hB,        1, 0, 1, 1,  32'hA);
        tbl[4]  = mk(1, 1,  32'hA,        1, 2,  32'hB,        0, 1, 1, 2,  32'hB);
        tbl[5]  = mk(1, 1,  32'hA,        1, 2,  32'hB,        1, 0, 1, 1,  32'hA);
        tbl[6]  = mk(1, 1,  32'hA,        1, 2,  32'hB,        0, 1, 1, 2,  32'hB);
        tbl[7]  = mk(1, 1,  32'hA,        0, 0,  0,            1, 0, 1, 1,  32'hA);
        tbl[8]  = mk(0, 0,  0,            1, 0,  32'hFFFFFFFF, 0, 1, 0, 0,  32'hFFFFFFFF);
        tbl[9]  = mk(1, 3,  32'h33,       0, 0,  0,            1, 0, 1, 3,  32'h33);
        tbl[10] = mk(1, 7,  32'h11,       1, 7,  32'h22,       0, 1, 1, 7,  32'h22);
        tbl[11] = mk(1, 7,  32'h11,       0, 0,  0,            1, 0, 1, 7,  32'h11);
        tbl[12] = mk(0, 0,  0,            0, 0,  0,            0, 0, 0, 7,  32'h11);

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_WE3", 32'(WE3), 32'd0);
        chk("rst_A3", 32'(A3), 32'd0);
        chk("rst_WD3", WD3, 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        reset = 1'b0;

        sweep(32, 1'b1);

        for (int k = 0; k < 13; k++) begin
            cur = tbl[k];
            if (k > 0) begin
                prev = tbl[k-1];
                if (prev.av && !prev.er_a &&
                    !(cur.av && cur.aa == prev.aa && cur.ad == prev.ad)) begin
                    n_err++;
                    $display("FAIL hold_a vector %0d: requester A changed before acceptance", k);
                end
                if (prev.bv && !prev.er_b &&
                    !(cur.bv && cur.ba == prev.ba && cur.bd == prev.bd)) begin
                    n_err++;
                    $display("FAIL hold_b vector %0d: requester B changed before acceptance", k);
                end
            end
            $display("vector %0d", k);
            apply(cur);
        end

        // Reset while a request is being accepted: the write must be discarded.
        drive(1, 4, 32'h44, 0, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrun_WE3", 32'(WE3), 32'd0);
        chk("midrun_A3", 32'(A3), 32'd0);
        chk("midrun_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        drive(1, 6, 32'h66, 1, 8, 32'h88);

        sweep(10, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midsweep_WE3", 32'(WE3), 32'd0);
        chk("midsweep_A3", 32'(A3), 32'd0);
        chk("midsweep_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        sweep(32, 1'b1);

        // Pointer is back to B after reset, so A wins the first tie.
        apply(mk(1, 6, 32'h66, 1, 8, 32'h88, 1, 0, 1, 6, 32'h66));
        apply(mk(0, 0, 0,      1, 8, 32'h88, 0, 1, 1, 8, 32'h88));
        apply(mk(0, 0, 0,      0, 0, 0,      0, 0, 0, 8, 32'h88));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
